hazard_forward_unit: RTL and testbench
======================================

// Module: hazard_forward_unit
// PURPOSE
//  Parametrised successor to the EX-stage forwarding unit. Combines operand-forward selection with
//  load-use hazard detection and a multi-cycle (MUL/DIV) scoreboard in one stall controller.
//  Sits beside the ID/EX pipeline registers. Drives ALU operand muxes, PC/IF-ID write enables and ID/EX bubble insertion.
// PARAMETERS
//  RA_W      5   register-address width (register 0 is hard-wired zero, never a forward/hazard source)
//  MC_LAT    4   multi-cycle unit latency in cycles, issue to result; legal range 2..15
//  CNT_W     16  width of saturating stall-cycle counter
//  MC_FWD_EN 1   1: forward multi-cycle result on completion cycle (select 2'b11); 0: never emit 2'b11
// PORTS
//  clk          in   1     clock, rising edge
//  rst_n        in   1     asynchronous active-low reset
//  RsID, RtID   in   RA_W  source regs of instruction in ID
//  UsesRsID     in   1     ID instruction actually reads Rs
//  UsesRtID     in   1     ID instruction actually reads Rt
//  McOpID       in   1     ID instruction is a multi-cycle op
//  RsEX, RtEX   in   RA_W  source regs of instruction in EX (ID/EX)
//  WriteRegEX   in   RA_W  destination of EX instruction
//  RegWriteEX   in   1     EX instruction writes the register file
//  MemReadEX    in   1     EX instruction is a load
//  McStartEX    in   1     multi-cycle op issuing from EX this cycle (pipeline copy carries RegWrite=0)
//  WriteRegMEM  in   RA_W  EX/MEM destination
//  RegWriteMEM  in   1     EX/MEM write enable
//  WriteRegWB   in   RA_W  MEM/WB destination
//  RegWriteWB   in   1     MEM/WB write enable
//  ForwardA     out  2     RsEX operand select: 00 RF, 01 EX/MEM, 10 MEM/WB, 11 MC result
//  ForwardB     out  2     RtEX operand select, same encoding
//  PCWrite      out  1     PC update enable
//  IFIDWrite    out  1     IF/ID update enable
//  IDEXFlush    out  1     insert bubble into ID/EX
//  McBusy       out  1     scoreboard holds a pending MC destination
//  McDone       out  1     MC result valid this cycle, write RF at McDest
//  McDest       out  RA_W  pending MC destination register
//  ErrOverlap   out  1     sticky: McStartEX seen while McBusy
//  StallCycles  out  CNT_W saturating count of cycles with PCWrite=0
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE, count 0, McDest 0, ErrOverlap 0, StallCycles 0.
//   Outputs then read Forward*=00 (absent matches), PCWrite=IFIDWrite=1, IDEXFlush=0, McBusy=McDone=0.
//  Forwarding (combinational, 0-cycle), per operand X in {Rs,Rt}, first match wins:
//   1) MC_FWD_EN && McDone && XEX==McDest && McDest!=0 -> 11
//   2) RegWriteMEM && WriteRegMEM!=0 && XEX==WriteRegMEM -> 01
//   3) RegWriteWB && WriteRegWB!=0 && XEX==WriteRegWB -> 10
//   4) otherwise 00.
//   Write-enable gating is mandatory. EX/MEM beats MEM/WB on a double match.
//  Load-use: MemReadEX && RegWriteEX && WriteRegEX!=0 && ((UsesRsID && RsID==WriteRegEX) || (UsesRtID && RtID==WriteRegEX)).
//   Result is a one-cycle stall, no state.
//  Scoreboard FSM:
//   IDLE --McStartEX--> BUSY; load count=MC_LAT-1 and McDest=WriteRegEX.
//   BUSY: count decrements each cycle. McDone=1 when count==0. The next edge returns to IDLE.
//   McStartEX in the same cycle as McDone re-arms BUSY with the new destination. Not an overlap.
//   McStartEX in BUSY with count!=0 is ignored and sets ErrOverlap.
//  MC hazard (BUSY && count!=0): ID reads McDest (UsesX && X==McDest && McDest!=0), or McOpID=1.
//  Stall = load-use OR MC hazard -> PCWrite=0, IFIDWrite=0, IDEXFlush=1, all in the same cycle.
//  StallCycles increments on every stall cycle and saturates at all-ones.
//  McBusy = (state==BUSY).
// STRUCTURE
//  Shared package pipe_pkg: FWD_RF/FWD_EXMEM/FWD_MEMWB/FWD_MC 2-bit constants, fsm state enum (IDLE, BUSY).
//  One sub-module, fwd_select, instantiated twice (Rs, Rt) with the priority chain. Remainder flat.
// TESTING
//  RegWriteMEM=1, WriteRegMEM=8, RegWriteWB=1, WriteRegWB=8, RsEX=8 -> ForwardA=01.
//   Then RegWriteMEM=0 -> ForwardA=10.
//  WriteRegMEM=0, RegWriteMEM=1, RsEX=0 -> ForwardA=00. Also RtEX=9 with RegWriteWB=0 -> ForwardB=00.
//  MemReadEX=1, RegWriteEX=1, WriteRegEX=5, RtID=5, UsesRtID=1 -> exactly 1 cycle of PCWrite=0/IDEXFlush=1.
//   StallCycles +1.
//  McStartEX with WriteRegEX=12, MC_LAT=4, ID reads r12 -> stall 3 cycles, McDone on 4th.
//   RsEX=12 that cycle -> ForwardA=11.
//  McStartEX while count=2 -> ignored, ErrOverlap=1 stays set. Also rst_n low mid-BUSY -> IDLE, McBusy=0.
//   Also stall released on the next cycle.
//  Force 2^CNT_W+3 stall cycles (CNT_W=4 build) -> StallCycles holds 4'hF.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared encodings for the EX-stage forwarding and stall controller.
// Operand-select codes and the multi-cycle scoreboard state type.
package pipe_pkg;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;
    localparam logic [1:0] FWD_MC    = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mcState_t;

endpackage

// File: rtl/hazard_forward_unit_fwd_select.sv
// Priority chain choosing one ALU operand source: MC result, EX/MEM, MEM/WB, then register file.
// Purely combinational, zero latency; never stalls.
module fwd_select
    import pipe_pkg::*;
#(
    parameter int RA_W      = 5,
    parameter bit MC_FWD_EN = 1'b1
) (
    input  logic [RA_W-1:0] srcEX,
    input  logic            mcDone,
    input  logic [RA_W-1:0] mcDest,
    input  logic [RA_W-1:0] writeRegMEM,
    input  logic            regWriteMEM,
    input  logic [RA_W-1:0] writeRegWB,
    input  logic            regWriteWB,
    output logic [1:0]      fwdSel
);

    always_comb begin
        fwdSel = FWD_RF;
        if (MC_FWD_EN && mcDone && (mcDest != '0) && (srcEX == mcDest)) begin
            fwdSel = FWD_MC;
        end else if (regWriteMEM && (writeRegMEM != '0) && (srcEX == writeRegMEM)) begin
            fwdSel = FWD_EXMEM;
        end else if (regWriteWB && (writeRegWB != '0) && (srcEX == writeRegWB)) begin
            fwdSel = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/hazard_forward_unit.sv
// Operand forwarding, load-use detection and multi-cycle scoreboard driving pipeline stall/bubble.
// Forward selects and stall are same-cycle combinational; scoreboard state updates on the clock edge.
module hazard_forward_unit
    import pipe_pkg::*;
#(
    parameter int RA_W      = 5,
    parameter int MC_LAT    = 4,
    parameter int CNT_W     = 16,
    parameter bit MC_FWD_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [RA_W-1:0]  RsID,
    input  logic [RA_W-1:0]  RtID,
    input  logic             UsesRsID,
    input  logic             UsesRtID,
    input  logic             McOpID,
    input  logic [RA_W-1:0]  RsEX,
    input  logic [RA_W-1:0]  RtEX,
    input  logic [RA_W-1:0]  WriteRegEX,
    input  logic             RegWriteEX,
    input  logic             MemReadEX,
    input  logic             McStartEX,
    input  logic [RA_W-1:0]  WriteRegMEM,
    input  logic             RegWriteMEM,
    input  logic [RA_W-1:0]  WriteRegWB,
    input  logic             RegWriteWB,
    output logic [1:0]       ForwardA,
    output logic [1:0]       ForwardB,
    output logic             PCWrite,
    output logic             IFIDWrite,
    output logic             IDEXFlush,
    output logic             McBusy,
    output logic             McDone,
    output logic [RA_W-1:0]  McDest,
    output logic             ErrOverlap,
    output logic [CNT_W-1:0] StallCycles
);

    localparam int CW = 4;
    localparam logic [CW-1:0] LAT_LOAD = CW'(MC_LAT - 1);

    mcState_t      state, stateNext;
    logic [CW-1:0] count, countNext;
    logic [RA_W-1:0] destNext;
    logic          errSet;
    logic          mcPending;
    logic          loadUse;
    logic          mcHazard;
    logic          stall;

    fwd_select #(.RA_W(RA_W), .MC_FWD_EN(MC_FWD_EN)) uFwdA (
        .srcEX(RsEX), .mcDone(McDone), .mcDest(McDest),
        .writeRegMEM(WriteRegMEM), .regWriteMEM(RegWriteMEM),
        .writeRegWB(WriteRegWB), .regWriteWB(RegWriteWB),
        .fwdSel(ForwardA)
    );

    fwd_select #(.RA_W(RA_W), .MC_FWD_EN(MC_FWD_EN)) uFwdB (
        .srcEX(RtEX), .mcDone(McDone), .mcDest(McDest),
        .writeRegMEM(WriteRegMEM), .regWriteMEM(RegWriteMEM),
        .writeRegWB(WriteRegWB), .regWriteWB(RegWriteWB),
        .fwdSel(ForwardB)
    );

    assign McBusy    = (state == BUSY);
    assign McDone    = McBusy && (count == '0);
    assign mcPending = McBusy && (count != '0);

    assign loadUse = MemReadEX && RegWriteEX && (WriteRegEX != '0) &&
                     ((UsesRsID && (RsID == WriteRegEX)) || (UsesRtID && (RtID == WriteRegEX)));

    // The completion cycle itself does not stall: the result is forwarded instead.
    assign mcHazard = mcPending &&
                      (McOpID || ((McDest != '0) &&
                       ((UsesRsID && (RsID == McDest)) || (UsesRtID && (RtID == McDest)))));

    assign stall     = loadUse || mcHazard;
    assign PCWrite   = !stall;
    assign IFIDWrite = !stall;
    assign IDEXFlush = stall;

    always_comb begin
        stateNext = state;
        countNext = count;
        destNext  = McDest;
        errSet    = 1'b0;
        case (state)
            IDLE: begin
                if (McStartEX) begin
                    stateNext = BUSY;
                    countNext = LAT_LOAD;
                    destNext  = WriteRegEX;
                end
            end
            BUSY: begin
                if (count == '0) begin
                    // A new issue on the completion cycle chains straight into the next op.
                    if (McStartEX) begin
                        countNext = LAT_LOAD;
                        destNext  = WriteRegEX;
                    end else begin
                        stateNext = IDLE;
                    end
                end else begin
                    countNext = count - 1'b1;
                    errSet    = McStartEX;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            count       <= '0;
            McDest      <= '0;
            ErrOverlap  <= 1'b0;
            StallCycles <= '0;
        end else begin
            state      <= stateNext;
            count      <= countNext;
            McDest     <= destNext;
            ErrOverlap <= ErrOverlap | errSet;
            if (stall && (StallCycles != '1)) begin
                StallCycles <= StallCycles + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Table-driven and sequence checks of forwarding, load-use and scoreboard behaviour.
// Expected outputs are queued at drive time and popped at the following falling edge.
module tb_hazard_forward_unit;

    localparam int CNT_W = 4;

    typedef struct packed {
        logic [4:0] RsID;
        logic [4:0] RtID;
        logic       UsesRsID;
        logic       UsesRtID;
        logic       McOpID;
        logic [4:0] RsEX;
        logic [4:0] RtEX;
        logic [4:0] WriteRegEX;
        logic       RegWriteEX;
        logic       MemReadEX;
        logic       McStartEX;
        logic [4:0] WriteRegMEM;
        logic       RegWriteMEM;
        logic [4:0] WriteRegWB;
        logic       RegWriteWB;
    } vin_t;

    typedef struct packed {
        logic [1:0] fa;
        logic [1:0] fb;
        logic       st;
        logic       busy;
        logic       done;
        logic [4:0] dest;
        logic       err;
    } exp_t;

    typedef struct {
        vin_t  i;
        exp_t  e;
        string nm;
    } vec_t;

    logic clk, rst_n;
    logic [4:0] RsID, RtID, RsEX, RtEX, WriteRegEX, WriteRegMEM, WriteRegWB;
    logic UsesRsID, UsesRtID, McOpID, RegWriteEX, MemReadEX, McStartEX, RegWriteMEM, RegWriteWB;
    logic [1:0] ForwardA, ForwardB;
    logic PCWrite, IFIDWrite, IDEXFlush, McBusy, McDone, ErrOverlap;
    logic [4:0] McDest;
    logic [CNT_W-1:0] StallCycles;

    int errors = 0;
    int checks = 0;
    logic [CNT_W-1:0] expStall;
    exp_t q[$];
    vec_t tbl[12];

    hazard_forward_unit #(.RA_W(5), .MC_LAT(4), .CNT_W(CNT_W), .MC_FWD_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .RsID(RsID), .RtID(RtID), .UsesRsID(UsesRsID), .UsesRtID(UsesRtID), .McOpID(McOpID),
        .RsEX(RsEX), .RtEX(RtEX), .WriteRegEX(WriteRegEX), .RegWriteEX(RegWriteEX),
        .MemReadEX(MemReadEX), .McStartEX(McStartEX),
        .WriteRegMEM(WriteRegMEM), .RegWriteMEM(RegWriteMEM),
        .WriteRegWB(WriteRegWB), .RegWriteWB(RegWriteWB),
        .ForwardA(ForwardA), .ForwardB(ForwardB), .PCWrite(PCWrite), .IFIDWrite(IFIDWrite),
        .IDEXFlush(IDEXFlush), .McBusy(McBusy), .McDone(McDone), .McDest(McDest),
        .ErrOverlap(ErrOverlap), .StallCycles(StallCycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vin_t fi(input logic [4:0] rsEX, input logic [4:0] rtEX,
                                input logic rwm, input logic [4:0] wrm,
                                input logic rwb, input logic [4:0] wrb);
        vin_t v;
        v = '0;
        v.RsEX = rsEX; v.RtEX = rtEX;
        v.RegWriteMEM = rwm; v.WriteRegMEM = wrm;
        v.RegWriteWB = rwb; v.WriteRegWB = wrb;
        return v;
    endfunction

    function automatic vin_t li(input logic [4:0] rsID, input logic [4:0] rtID,
                                input logic uRs, input logic uRt,
                                input logic [4:0] wrEX, input logic rwEX, input logic mrd);
        vin_t v;
        v = '0;
        v.RsID = rsID; v.RtID = rtID; v.UsesRsID = uRs; v.UsesRtID = uRt;
        v.WriteRegEX = wrEX; v.RegWriteEX = rwEX; v.MemReadEX = mrd;
        return v;
    endfunction

    function automatic vin_t mc(input logic start, input logic [4:0] wrEX, input logic mcOp);
        vin_t v;
        v = '0;
        v.McStartEX = start; v.WriteRegEX = wrEX; v.McOpID = mcOp;
        return v;
    endfunction

    function automatic exp_t ex(input logic [1:0] fa, input logic [1:0] fb, input logic st,
                                input logic busy, input logic done, input logic [4:0] dest,
                                input logic err);
        exp_t e;
        e.fa = fa; e.fb = fb; e.st = st; e.busy = busy; e.done = done; e.dest = dest; e.err = err;
        return e;
    endfunction

    task automatic drive(input vin_t v);
        RsID = v.RsID; RtID = v.RtID; UsesRsID = v.UsesRsID; UsesRtID = v.UsesRtID;
        McOpID = v.McOpID; RsEX = v.RsEX; RtEX = v.RtEX; WriteRegEX = v.WriteRegEX;
        RegWriteEX = v.RegWriteEX; MemReadEX = v.MemReadEX; McStartEX = v.McStartEX;
        WriteRegMEM = v.WriteRegMEM; RegWriteMEM = v.RegWriteMEM;
        WriteRegWB = v.WriteRegWB; RegWriteWB = v.RegWriteWB;
    endtask

    task automatic compare(input string nm);
        exp_t e;
        logic [18:0] act, req;
        checks++;
        if (q.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty, nothing to compare against", nm);
        end else begin
            e = q.pop_front();
            act = {ForwardA, ForwardB, PCWrite, IFIDWrite, IDEXFlush, McBusy, McDone,
                   McDest, ErrOverlap, StallCycles};
            req = {e.fa, e.fb, ~e.st, ~e.st, e.st, e.busy, e.done, e.dest, e.err, expStall};
            if (act !== req) begin
                errors++;
                $display("FAIL %s: got fa=%b fb=%b pcw=%b ifw=%b fl=%b busy=%b done=%b dest=%0d err=%b cnt=%0d required %h (got %h)",
                         nm, ForwardA, ForwardB, PCWrite, IFIDWrite, IDEXFlush, McBusy, McDone,
                         McDest, ErrOverlap, StallCycles, req, act);
            end
            if (e.st && expStall != {CNT_W{1'b1}}) expStall = expStall + 1'b1;
        end
    endtask

    // Entered just after a rising edge; returns just after the next one.
    task automatic step(input vin_t v, input exp_t e, input string nm);
        drive(v);
        q.push_back(e);
        @(negedge clk);
        compare(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic resetCheck(input string nm);
        rst_n = 1'b0;
        #1;
        expStall = '0;
        q.push_back(ex(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0));
        compare(nm);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        expStall = '0;
        drive('0);
        rst_n = 1'b0;
        #3;
        q.push_back(ex(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0));
        compare("reset_state");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        tbl[0]  = '{fi(8, 0, 1, 8, 1, 8),              ex(2'b01, 2'b00, 0, 0, 0, 0, 0), "fwd_exmem_beats_memwb"};
        tbl[1]  = '{fi(8, 0, 0, 8, 1, 8),              ex(2'b10, 2'b00, 0, 0, 0, 0, 0), "fwd_memwb"};
        tbl[2]  = '{fi(0, 9, 1, 0, 0, 9),              ex(2'b00, 2'b00, 0, 0, 0, 0, 0), "fwd_r0_and_gated_wb"};
        tbl[3]  = '{fi(3, 9, 1, 3, 1, 9),              ex(2'b01, 2'b10, 0, 0, 0, 0, 0), "fwd_split_ab"};
        tbl[4]  = '{fi(9, 9, 1, 3, 0, 9),              ex(2'b00, 2'b00, 0, 0, 0, 0, 0), "fwd_wb_gated"};
        tbl[5]  = '{li(0, 5, 0, 1, 5, 1, 1),           ex(2'b00, 2'b00, 1, 0, 0, 0, 0), "loaduse_rt_stall"};
        tbl[6]  = '{li(0, 5, 0, 1, 5, 1, 0),           ex(2'b00, 2'b00, 0, 0, 0, 0, 0), "loaduse_released"};
        tbl[7]  = '{li(0, 5, 0, 0, 5, 1, 1),           ex(2'b00, 2'b00, 0, 0, 0, 0, 0), "loaduse_rt_unused"};
        tbl[8]  = '{li(0, 0, 1, 1, 0, 1, 1),           ex(2'b00, 2'b00, 0, 0, 0, 0, 0), "loaduse_r0"};
        tbl[9]  = '{li(7, 0, 1, 0, 7, 0, 1),           ex(2'b00, 2'b00, 0, 0, 0, 0, 0), "loaduse_no_regwrite"};
        tbl[10] = '{li(7, 0, 1, 0, 7, 1, 1),           ex(2'b00, 2'b00, 1, 0, 0, 0, 0), "loaduse_rs_stall"};
        tbl[11] = '{vin_t'(fi(7, 7, 1, 7, 1, 2) | li(2, 0, 1, 0, 3, 1, 1)),
                                                       ex(2'b01, 2'b01, 0, 0, 0, 0, 0), "fwd_with_load_no_match"};

        for (int k = 0; k < 12; k++) step(tbl[k].i, tbl[k].e, tbl[k].nm);

        // MC op to r12, ID reads r12 while pending, result forwarded on completion.
        step(mc(1, 12, 0), ex(2'b00, 2'b00, 0, 0, 0, 0, 0), "mc_issue");
        for (int k = 0; k < 3; k++)
            step(li(12, 0, 1, 0, 0, 0, 0), ex(2'b00, 2'b00, 1, 1, 0, 12, 0), $sformatf("mc_stall_%0d", k));
        step(vin_t'(fi(12, 12, 1, 12, 0, 0) | li(12, 0, 1, 0, 0, 0, 0)),
             ex(2'b11, 2'b11, 0, 1, 1, 12, 0), "mc_done_fwd");
        step(fi(12, 0, 0, 0, 0, 0), ex(2'b00, 2'b00, 0, 0, 0, 12, 0), "mc_back_idle");

        // Overlapping issue is dropped and flagged; flag is sticky.
        step(mc(1, 4, 0), ex(2'b00, 2'b00, 0, 0, 0, 12, 0), "ov_issue");
        step(mc(0, 0, 0), ex(2'b00, 2'b00, 0, 1, 0, 4, 0), "ov_busy_cnt3");
        step(mc(1, 6, 0), ex(2'b00, 2'b00, 0, 1, 0, 4, 0), "ov_start_cnt2");
        step(mc(0, 0, 1), ex(2'b00, 2'b00, 1, 1, 0, 4, 1), "ov_err_set_mcop_stall");
        step(mc(0, 0, 1), ex(2'b00, 2'b00, 0, 1, 1, 4, 1), "ov_done_dest_kept");
        step(mc(0, 0, 0), ex(2'b00, 2'b00, 0, 0, 0, 4, 1), "ov_err_sticky");

        // Re-arm on the completion cycle is a legal chain.
        step(mc(1, 10, 0), ex(2'b00, 2'b00, 0, 0, 0, 4, 1), "rearm_issue");
        for (int k = 0; k < 3; k++)
            step(mc(0, 0, 0), ex(2'b00, 2'b00, 0, 1, 0, 10, 1), $sformatf("rearm_busy_%0d", k));
        step(mc(1, 11, 0), ex(2'b00, 2'b00, 0, 1, 1, 10, 1), "rearm_on_done");
        step(li(0, 11, 0, 1, 0, 0, 0), ex(2'b00, 2'b00, 1, 1, 0, 11, 1), "rearm_new_dest_stall");

        resetCheck("reset_mid_busy");
        step(li(0, 11, 0, 1, 0, 0, 0), ex(2'b00, 2'b00, 0, 0, 0, 0, 0), "stall_released_after_reset");

        for (int k = 0; k < (1 << CNT_W) + 3; k++)
            step(li(0, 5, 0, 1, 5, 1, 1), ex(2'b00, 2'b00, 1, 0, 0, 0, 0), $sformatf("sat_%0d", k));
        step('0, ex(2'b00, 2'b00, 0, 0, 0, 0, 0), "stall_count_saturated");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
